obi_varlat_rr_mux: RTL and testbench

OBI_VARLAT_RR_MUX -- requirements
Module: obi_varlat_rr_mux

---
 rtl/obi_mux_pkg.sv | 13 +
 rtl/obi_pkg.sv | 22 ++
 rtl/obi_id_fifo.sv | 61 ++++++
 rtl/obi_varlat_rr_mux.sv | 127 ++++++++++++
 tb/tb_obi_varlat_rr_mux.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_mux_pkg.sv
// Arbitration modes and sizing helper for the OBI multiplexer.
package obi_mux_pkg;

  typedef enum logic {
    ARB_RR,
    ARB_FIXED
  } arb_mode_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by masters, slaves and interconnect.
package obi_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of granted master indices; the head names the owner of the next response.
module obi_id_fifo
  import obi_mux_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned DW    = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = idx_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop_ok) begin
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_varlat_rr_mux.sv
// N-to-1 OBI multiplexer with round-robin or fixed-priority arbitration and
// in-order routing of variable-latency responses back to their masters.
module obi_varlat_rr_mux
  import obi_pkg::*;
  import obi_mux_pkg::*;
#(
  parameter  int unsigned NMASTER         = 4,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  arb_mode_e   ARB_MODE        = ARB_RR,
  localparam int unsigned IW              = idx_width(NMASTER),
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  master_req_i  [NMASTER],
  output obi_resp_t master_resp_o [NMASTER],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic [CW-1:0] outstanding_o,
  output logic      err_o
);

  logic [NMASTER-1:0] req_vec;
  logic               any_req;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      base;
  logic [IW:0]        sum;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      sel;
  logic               lock_q;
  logic [IW-1:0]      lock_sel_q;
  logic               req_out;
  logic               handshake;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IW-1:0]      head;
  logic               err_q;

  for (genvar g = 0; g < NMASTER; g++) begin : g_req_vec
    assign req_vec[g] = master_req_i[g].req;
  end

  assign any_req = |req_vec;
  assign base    = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  // Scan downwards so the first requester at or after base wins last.
  always_comb begin
    cand = '0;
    sum  = '0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      sum = {1'b0, base} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(NMASTER)) begin
        sum = sum - (IW + 1)'(NMASTER);
      end
      if (req_vec[sum[IW-1:0]]) begin
        cand = sum[IW-1:0];
      end
    end
  end

  assign sel       = lock_q ? lock_sel_q : cand;
  assign req_out   = any_req && !fifo_full && rst_ni;
  assign handshake = req_out && slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid && !fifo_empty;

  always_comb begin
    slave_req_o = '0;
    if (req_out) begin
      slave_req_o     = master_req_i[sel];
      slave_req_o.req = 1'b1;
    end
  end

  for (genvar g = 0; g < NMASTER; g++) begin : g_resp
    assign master_resp_o[g].gnt    = handshake && (sel == IW'(g));
    assign master_resp_o[g].rvalid = pop && (head == IW'(g));
    assign master_resp_o[g].rdata  = slave_resp_i.rdata;
  end

  // Freeze the selection during a stalled request so addr/data stay stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else if (handshake) begin
      lock_q     <= 1'b0;
    end else if (req_out) begin
      lock_q     <= 1'b1;
      lock_sel_q <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (handshake && (ARB_MODE == ARB_RR)) begin
      rr_ptr <= (sel == IW'(NMASTER - 1)) ? '0 : sel + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (slave_resp_i.rvalid && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (IW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .wdata  (sel),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (outstanding_o)
  );

endmodule

// File: tb/tb_obi_varlat_rr_mux.sv
// Directed self-checking bench for obi_varlat_rr_mux (NMASTER=4, MAX_OUTSTANDING=2, round-robin).
module tb_obi_varlat_rr_mux;
  import obi_pkg::*;
  import obi_mux_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  obi_req_t  mreq  [4];
  obi_resp_t mresp [4];
  obi_req_t  sreq;
  obi_resp_t sresp = '0;
  logic [1:0] outstanding;
  logic      err;
  logic [3:0] gvec;
  logic [3:0] rvec;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obi_varlat_rr_mux #(
    .NMASTER         (4),
    .MAX_OUTSTANDING (2),
    .ARB_MODE        (ARB_RR)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign gvec[g] = mresp[g].gnt;
    assign rvec[g] = mresp[g].rvalid;
  end

  function automatic logic [31:0] addr_of(input int i);
    return 32'h0000_1000 + 32'(i) * 32'h100;
  endfunction

  task automatic set_reqs(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      mreq[i].req   = v[i];
      mreq[i].we    = v[i];
      mreq[i].be    = 4'hF;
      mreq[i].addr  = addr_of(i);
      mreq[i].wdata = 32'hD000_0000 + 32'(i);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    set_reqs(4'h0);
    sresp = '0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    next_cycle();
    set_reqs(4'hF);
    sresp.gnt = 1'b1;
    sresp.rvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (sreq.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_slave_req: got %b want 0", sreq.req); end
    checks++; if (gvec !== 4'h0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0000", gvec); end
    checks++; if (rvec !== 4'h0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0000", rvec); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("[TB] FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    next_cycle();
    set_reqs(4'h0);
    sresp = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int qm[$];
    int qd[$];
    bit sent;
    do_reset();
    for (int c = 0; c < 40 && (n < 5 || qm.size() > 0); c++) begin
      next_cycle();
      set_reqs(n < 5 ? 4'hF : 4'h0);
      sent = (qd.size() > 0) && (qd[0] == c);
      sresp.gnt    = 1'b1;
      sresp.rvalid = sent;
      sresp.rdata  = 32'hA000_0000 + 32'(c);
      #1;
      if (sent) begin
        checks++;
        if (rvec !== 4'(1 << qm[0])) begin errors++; $display("[TB] FAIL rr_rvalid_route: got %b want %b", rvec, 4'(1 << qm[0])); end
        void'(qm.pop_front());
        void'(qd.pop_front());
      end else begin
        checks++;
        if (rvec !== 4'h0) begin errors++; $display("[TB] FAIL rr_rvalid_idle: got %b want 0000", rvec); end
      end
      if (sreq.req === 1'b1) begin
        checks++;
        if (n >= 5 || gvec !== 4'(1 << exp_order[n]) || sreq.addr !== addr_of(exp_order[n])) begin
          errors++;
          $display("[TB] FAIL rr_grant_order: grant #%0d got gnt=%b addr=%h", n, gvec, sreq.addr);
        end
        if (n < 5) begin
          qm.push_back(exp_order[n]);
          qd.push_back(c + 2);
          n++;
        end
      end else begin
        checks++;
        if (gvec !== 4'h0) begin errors++; $display("[TB] FAIL rr_gnt_without_req: got %b want 0000", gvec); end
      end
    end
    sresp = '0;
    checks++;
    if (n != 5 || qm.size() != 0) begin errors++; $display("[TB] FAIL rr_timeout: got %0d grants want 5, pending %0d want 0", n, qm.size()); end
  endtask

  task automatic test_stall_stability();
    do_reset();
    next_cycle();
    set_reqs(4'b0100);
    sresp.gnt = 1'b0;
    #1;
    checks++; if (sreq.req !== 1'b1 || sreq.addr !== addr_of(2)) begin errors++; $display("[TB] FAIL stall_first_sel: got req=%b addr=%h want 1/%h", sreq.req, sreq.addr, addr_of(2)); end
    checks++; if (gvec !== 4'h0) begin errors++; $display("[TB] FAIL stall_no_gnt: got %b want 0000", gvec); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      set_reqs(4'b0101);
      #1;
      checks++; if (sreq.addr !== addr_of(2) || gvec !== 4'h0) begin errors++; $display("[TB] FAIL stall_held: got addr=%h gnt=%b want %h/0000", sreq.addr, gvec, addr_of(2)); end
    end
    next_cycle();
    sresp.gnt = 1'b1;
    #1;
    checks++; if (gvec !== 4'b0100 || sreq.addr !== addr_of(2)) begin errors++; $display("[TB] FAIL stall_grant_m2: got gnt=%b addr=%h want 0100/%h", gvec, sreq.addr, addr_of(2)); end
    next_cycle();
    set_reqs(4'b0001);
    #1;
    checks++; if (gvec !== 4'b0001 || sreq.addr !== addr_of(0)) begin errors++; $display("[TB] FAIL stall_grant_m0: got gnt=%b addr=%h want 0001/%h", gvec, sreq.addr, addr_of(0)); end
    next_cycle();
    set_reqs(4'h0);
    sresp.gnt = 1'b0;
    sresp.rvalid = 1'b1;
    #1;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("[TB] FAIL stall_outstanding: got %0d want 2", outstanding); end
    checks++; if (rvec !== 4'b0100) begin errors++; $display("[TB] FAIL stall_resp_m2: got %b want 0100", rvec); end
    next_cycle();
    #1;
    checks++; if (rvec !== 4'b0001) begin errors++; $display("[TB] FAIL stall_resp_m0: got %b want 0001", rvec); end
    next_cycle();
    sresp.rvalid = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0) begin errors++; $display("[TB] FAIL stall_drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    next_cycle();
    set_reqs(4'b1010);
    sresp.gnt = 1'b1;
    #1;
    checks++; if (gvec !== 4'b0010) begin errors++; $display("[TB] FAIL full_grant1: got %b want 0010", gvec); end
    next_cycle();
    #1;
    checks++; if (gvec !== 4'b1000) begin errors++; $display("[TB] FAIL full_grant2: got %b want 1000", gvec); end
    next_cycle();
    set_reqs(4'b0010);
    sresp.rvalid = 1'b1;
    #1;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("[TB] FAIL full_count: got %0d want 2", outstanding); end
    checks++; if (sreq.req !== 1'b0 || gvec !== 4'h0) begin errors++; $display("[TB] FAIL full_blocks_req: got req=%b gnt=%b want 0/0000", sreq.req, gvec); end
    checks++; if (rvec !== 4'b0010) begin errors++; $display("[TB] FAIL full_resp_m1: got %b want 0010", rvec); end
    next_cycle();
    sresp.rvalid = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd1) begin errors++; $display("[TB] FAIL full_after_pop: got %0d want 1", outstanding); end
    checks++; if (sreq.req !== 1'b1 || gvec !== 4'b0010) begin errors++; $display("[TB] FAIL full_regrant: got req=%b gnt=%b want 1/0010", sreq.req, gvec); end
    next_cycle();
    set_reqs(4'h0);
    sresp.rvalid = 1'b1;
    #1;
    checks++; if (rvec !== 4'b1000) begin errors++; $display("[TB] FAIL full_resp_m3: got %b want 1000", rvec); end
    next_cycle();
    #1;
    checks++; if (rvec !== 4'b0010) begin errors++; $display("[TB] FAIL full_resp_m1b: got %b want 0010", rvec); end
    next_cycle();
    sresp = '0;
    #1;
    checks++; if (outstanding !== 2'd0) begin errors++; $display("[TB] FAIL full_drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_push_pop();
    do_reset();
    next_cycle();
    set_reqs(4'b0001);
    sresp.gnt = 1'b1;
    #1;
    checks++; if (gvec !== 4'b0001) begin errors++; $display("[TB] FAIL pp_grant_m0: got %b want 0001", gvec); end
    next_cycle();
    set_reqs(4'b0010);
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h5A5A_1234;
    #1;
    checks++; if (outstanding !== 2'd1) begin errors++; $display("[TB] FAIL pp_count_before: got %0d want 1", outstanding); end
    checks++; if (gvec !== 4'b0010) begin errors++; $display("[TB] FAIL pp_grant_m1: got %b want 0010", gvec); end
    checks++; if (rvec !== 4'b0001) begin errors++; $display("[TB] FAIL pp_resp_older: got %b want 0001", rvec); end
    checks++; if (mresp[3].rdata !== 32'h5A5A_1234) begin errors++; $display("[TB] FAIL pp_rdata_broadcast: got %h want 5a5a1234", mresp[3].rdata); end
    next_cycle();
    set_reqs(4'h0);
    sresp.gnt = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd1) begin errors++; $display("[TB] FAIL pp_count_after: got %0d want 1", outstanding); end
    checks++; if (rvec !== 4'b0010) begin errors++; $display("[TB] FAIL pp_resp_newer: got %b want 0010", rvec); end
    next_cycle();
    sresp = '0;
    #1;
    checks++; if (outstanding !== 2'd0) begin errors++; $display("[TB] FAIL pp_drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_spurious();
    do_reset();
    next_cycle();
    sresp.rvalid = 1'b1;
    #1;
    checks++; if (rvec !== 4'h0) begin errors++; $display("[TB] FAIL spur_no_rvalid: got %b want 0000", rvec); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL spur_err_early: got %b want 0", err); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sresp.rvalid = 1'b0;
      #1;
      checks++; if (err !== 1'b1 || outstanding !== 2'd0) begin errors++; $display("[TB] FAIL spur_err_sticky: got err=%b count=%0d want 1/0", err, outstanding); end
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL spur_err_reset: got %b want 0", err); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    set_reqs(4'hF);
    sresp.gnt = 1'b1;
    #1;
    checks++; if (gvec !== 4'b0001) begin errors++; $display("[TB] FAIL mid_pre_grant0: got %b want 0001", gvec); end
    next_cycle();
    #1;
    checks++; if (gvec !== 4'b0010) begin errors++; $display("[TB] FAIL mid_pre_grant1: got %b want 0010", gvec); end
    next_cycle();
    #1;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("[TB] FAIL mid_count2: got %0d want 2", outstanding); end
    #3;
    sresp.rvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0 || sreq.req !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_clear: got count=%0d req=%b want 0/0", outstanding, sreq.req); end
    checks++; if (gvec !== 4'h0 || rvec !== 4'h0 || err !== 1'b0) begin errors++; $display("[TB] FAIL mid_outputs_zero: got gnt=%b rvalid=%b err=%b want 0", gvec, rvec, err); end
    next_cycle();
    set_reqs(4'h0);
    sresp = '0;
    rst_n = 1'b1;
    next_cycle();
    sresp.rvalid = 1'b1;
    #1;
    checks++; if (rvec !== 4'h0) begin errors++; $display("[TB] FAIL mid_stale_rvalid: got %b want 0000", rvec); end
    next_cycle();
    sresp.rvalid = 1'b0;
    set_reqs(4'hF);
    sresp.gnt = 1'b1;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL mid_stale_err: got %b want 1", err); end
    checks++; if (gvec !== 4'b0001) begin errors++; $display("[TB] FAIL mid_restart_m0: got %b want 0001", gvec); end
    next_cycle();
    #1;
    checks++; if (gvec !== 4'b0010) begin errors++; $display("[TB] FAIL mid_restart_m1: got %b want 0010", gvec); end
    next_cycle();
    set_reqs(4'h0);
    sresp = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_reqs(4'h0);
    test_reset();
    test_rr_fairness();
    test_stall_stability();
    test_full_fifo();
    test_push_pop();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
